// File: rtl/gppcu_instr_fifo_ctrl_if.sv
// rtl/gppcu_instr_fifo_ctrl_if.sv - host command and core instruction handshake bundle
//
// Purpose: groups the host command port and the core instruction port of
//          gppcu_instr_fifo_ctrl into one interface.
// Signals:
//   iCMD_VALID   host command valid
//   oCMD_READY   command accepted when iCMD_VALID & oCMD_READY
//   iCMD_OP      0 PUSH, 1 FLUSH, 2 RD_STATUS, 3 reserved
//   iCMD_DATA    instruction word for PUSH
//   oINSTR       instruction at queue head
//   oINSTR_VALID oINSTR valid
//   iINSTR_READY core takes oINSTR when oINSTR_VALID & iINSTR_READY
// Modports:
//   slave  - the queue controller
//   master - the host/core side driving commands and consuming instructions
interface gppcu_instr_fifo_ctrl_if #(
  parameter int DW = 32
) ();
  logic          iCMD_VALID;
  logic          oCMD_READY;
  logic [1:0]    iCMD_OP;
  logic [DW-1:0] iCMD_DATA;
  logic [DW-1:0] oINSTR;
  logic          oINSTR_VALID;
  logic          iINSTR_READY;

  modport slave (
    input  iCMD_VALID,
    input  iCMD_OP,
    input  iCMD_DATA,
    input  iINSTR_READY,
    output oCMD_READY,
    output oINSTR,
    output oINSTR_VALID
  );

  modport master (
    output iCMD_VALID,
    output iCMD_OP,
    output iCMD_DATA,
    output iINSTR_READY,
    input  oCMD_READY,
    input  oINSTR,
    input  oINSTR_VALID
  );
endinterface

// File: rtl/gppcu_instr_fifo_ctrl.sv
// rtl/gppcu_instr_fifo_ctrl.sv - single-clock instruction queue between host command port and GPPCU_CORE
//
// Purpose: host pushes instructions, flushes the queue or snapshots status;
//          the core drains instructions first-word-fall-through style.
// Optional feature macro: GPPCU_CMDQ_STATS_EN (12-bit popped-instruction counter
//          reported in oSTATUS[31:20]; without it those bits read 0).
// Parameters:
//   DW      instruction width
//   AW      address width, depth 2**AW (AW <= 15 so oCOUNT fits oSTATUS[15:0])
//   AF_LVL  almost-full threshold
// Ports:
//   iACLK, iRST   clock, synchronous active-high reset
//   bus (slave)   command port and instruction port handshakes
//   oSTATUS       registered status snapshot taken by RD_STATUS
//   oCOUNT        occupancy 0..2**AW
//   oEMPTY, oFULL, oALMOST_FULL  occupancy flags
//   oOVERFLOW     sticky: a PUSH was offered while full
module gppcu_instr_fifo_ctrl #(
  parameter int DW     = 32,
  parameter int AW     = 7,
  parameter int AF_LVL = 2**AW - 4
) (
  input  logic                          iACLK,
  input  logic                          iRST,
  gppcu_instr_fifo_ctrl_if.slave        bus,
  output logic [31:0]                   oSTATUS,
  output logic [AW:0]                   oCOUNT,
  output logic                          oEMPTY,
  output logic                          oFULL,
  output logic                          oALMOST_FULL,
  output logic                          oOVERFLOW
);

  localparam int          DEPTH        = 2**AW;
  localparam logic [AW:0] AF_THR       = AF_LVL[AW:0];
  localparam logic [1:0]  OP_PUSH      = 2'd0;
  localparam logic [1:0]  OP_FLUSH     = 2'd1;
  localparam logic [1:0]  OP_RD_STATUS = 2'd2;

  // Storage and pointers. r_wr/r_rd are the architectural pointers that
  // define occupancy; r_fp is the fetch pointer feeding the read pipeline
  // and runs at most two entries ahead of r_rd.
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic [AW:0]   r_fp;

  // Two-stage read pipeline: stage A is the registered memory read,
  // stage B is the output register presented to the core.
  logic [DW-1:0] r_a_data;
  logic          r_a_valid;
  logic [DW-1:0] r_instr;
  logic          r_instr_valid;

  logic          r_overflow;
  logic [31:0]   r_status;

  logic [AW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_almost_full;
  logic          w_cmd_ready;
  logic          w_cmd_fire;
  logic          w_push;
  logic          w_flush;
  logic          w_rd_status;
  logic          w_push_ovf;
  logic          w_pop;
  logic          w_b_load;
  logic          w_fetch;
  logic [15:0]   w_count16;
  logic [11:0]   w_sfield;

  assign w_count       = r_wr - r_rd;
  assign w_empty       = (r_wr == r_rd);
  assign w_full        = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_almost_full = (w_count >= AF_THR);
  assign w_count16     = 16'(w_count);

  // Only a PUSH can be back-pressured; every other op is always accepted.
  assign w_cmd_ready = ~((bus.iCMD_OP == OP_PUSH) & w_full);
  assign w_cmd_fire  = bus.iCMD_VALID & w_cmd_ready;
  assign w_push      = w_cmd_fire & (bus.iCMD_OP == OP_PUSH);
  assign w_flush     = w_cmd_fire & (bus.iCMD_OP == OP_FLUSH);
  assign w_rd_status = w_cmd_fire & (bus.iCMD_OP == OP_RD_STATUS);
  assign w_push_ovf  = bus.iCMD_VALID & (bus.iCMD_OP == OP_PUSH) & w_full;

  assign w_pop = r_instr_valid & bus.iINSTR_READY;

  // Stage B refills from stage A when empty or being popped this cycle,
  // which keeps one instruction per cycle flowing during back-to-back pops.
  assign w_b_load = r_a_valid & (~r_instr_valid | w_pop);

  // Fetch only words written on an earlier edge (r_fp != r_wr pre-edge), so
  // the read never races a same-cycle write. This is what gives the two-cycle
  // push-to-valid latency.
  assign w_fetch = (r_fp != r_wr) & (~r_a_valid | w_b_load);

  always_ff @(posedge iACLK) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= bus.iCMD_DATA;
    end
  end

  always_ff @(posedge iACLK) begin
    if (iRST) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_fp          <= '0;
      r_a_data      <= '0;
      r_a_valid     <= 1'b0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_status      <= '0;
    end else if (w_flush) begin
      // Flush beats any push or pop in the same cycle; the popped word is lost.
      r_wr          <= '0;
      r_rd          <= '0;
      r_fp          <= '0;
      r_a_valid     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end

      if (w_fetch) begin
        r_fp     <= r_fp + 1'b1;
        r_a_data <= r_mem[r_fp[AW-1:0]];
      end

      if (w_fetch) begin
        r_a_valid <= 1'b1;
      end else if (w_b_load) begin
        r_a_valid <= 1'b0;
      end

      if (w_b_load) begin
        r_instr       <= r_a_data;
        r_instr_valid <= 1'b1;
      end else if (w_pop) begin
        r_instr_valid <= 1'b0;
      end

      if (w_push_ovf) begin
        r_overflow <= 1'b1;
      end

      if (w_rd_status) begin
        r_status <= {w_sfield, r_overflow, w_almost_full, w_full, w_empty, w_count16};
      end
    end
  end

`ifdef GPPCU_CMDQ_STATS_EN
  logic [11:0] r_pop_cnt;

  // Wrapping count of instructions actually taken by the core.
  always_ff @(posedge iACLK) begin
    if (iRST || w_flush) begin
      r_pop_cnt <= '0;
    end else if (w_pop) begin
      r_pop_cnt <= r_pop_cnt + 1'b1;
    end
  end

  assign w_sfield = r_pop_cnt;
`else
  assign w_sfield = 12'h000;
`endif

  assign bus.oCMD_READY   = w_cmd_ready;
  assign bus.oINSTR       = r_instr;
  assign bus.oINSTR_VALID = r_instr_valid;

  assign oSTATUS      = r_status;
  assign oCOUNT       = w_count;
  assign oEMPTY       = w_empty;
  assign oFULL        = w_full;
  assign oALMOST_FULL = w_almost_full;
  assign oOVERFLOW    = r_overflow;

endmodule

// File: tb/tb_gppcu_instr_fifo_ctrl.sv
// tb/tb_gppcu_instr_fifo_ctrl.sv - directed self-checking bench for gppcu_instr_fifo_ctrl
module tb_gppcu_instr_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int AF = 6;

  logic        clk;
  logic        rst;
  logic [31:0] status;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        overflow;

  int n_assert = 0;
  int n_fail   = 0;

  gppcu_instr_fifo_ctrl_if #(.DW(DW)) bus ();

  gppcu_instr_fifo_ctrl #(
    .DW     (DW),
    .AW     (AW),
    .AF_LVL (AF)
  ) u_dut (
    .iACLK        (clk),
    .iRST         (rst),
    .bus          (bus.slave),
    .oSTATUS      (status),
    .oCOUNT       (count),
    .oEMPTY       (empty),
    .oFULL        (full),
    .oALMOST_FULL (almost_full),
    .oOVERFLOW    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [31:0] data);
    bus.iCMD_VALID = 1'b1;
    bus.iCMD_OP    = op;
    bus.iCMD_DATA  = data;
    tick();
    bus.iCMD_VALID = 1'b0;
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] exp_status;

  initial begin
    bus.iCMD_VALID   = 1'b0;
    bus.iCMD_OP      = 2'd0;
    bus.iCMD_DATA    = '0;
    bus.iINSTR_READY = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(bus.oINSTR_VALID), 32'd0);
    chk("rst_instr", bus.oINSTR, 32'd0);
    chk("rst_status", status, 32'd0);
    chk("rst_cmd_ready", 32'(bus.oCMD_READY), 32'd1);

    // Three pushes, core always ready: valid two edges after first push
    bus.iINSTR_READY = 1'b1;
    cmd(2'd0, 32'hA1);
    chk("t1_valid_e0", 32'(bus.oINSTR_VALID), 32'd0);
    cmd(2'd0, 32'hA2);
    chk("t1_valid_e1", 32'(bus.oINSTR_VALID), 32'd0);
    cmd(2'd0, 32'hA3);
    chk("t1_valid_e2", 32'(bus.oINSTR_VALID), 32'd1);
    chk("t1_instr_a1", bus.oINSTR, 32'hA1);
    chk("t1_count3", 32'(count), 32'd3);
    tick();
    chk("t1_instr_a2", bus.oINSTR, 32'hA2);
    tick();
    chk("t1_instr_a3", bus.oINSTR, 32'hA3);
    chk("t1_valid_a3", 32'(bus.oINSTR_VALID), 32'd1);
    tick();
    chk("t1_valid_end", 32'(bus.oINSTR_VALID), 32'd0);
    chk("t1_empty_end", 32'(empty), 32'd1);

    // Fill to full, then offer a ninth push
    bus.iINSTR_READY = 1'b0;
    for (int i = 0; i < 8; i++) cmd(2'd0, 32'h10 + 32'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count8", 32'(count), 32'd8);
    chk("t2_af", 32'(almost_full), 32'd1);
    bus.iCMD_VALID = 1'b1;
    bus.iCMD_OP    = 2'd0;
    bus.iCMD_DATA  = 32'hEE;
    #1;
    chk("t2_ready_push_full", 32'(bus.oCMD_READY), 32'd0);
    tick();
    bus.iCMD_VALID = 1'b0;
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count_after_ovf", 32'(count), 32'd8);
    bus.iCMD_OP = 2'd1;
    #1;
    chk("t2_ready_flush_full", 32'(bus.oCMD_READY), 32'd1);
    bus.iINSTR_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_data", bus.oINSTR, 32'h10 + 32'(i));
      chk("t2_drain_valid", 32'(bus.oINSTR_VALID), 32'd1);
      tick();
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_valid_end", 32'(bus.oINSTR_VALID), 32'd0);

    // Four queued plus sticky overflow, FLUSH while core ready
    bus.iINSTR_READY = 1'b0;
    for (int i = 0; i < 4; i++) cmd(2'd0, 32'h30 + 32'(i));
    tick();
    tick();
    chk("t3_count4", 32'(count), 32'd4);
    chk("t3_ovf_pre", 32'(overflow), 32'd1);
    bus.iINSTR_READY = 1'b1;
    cmd(2'd1, 32'h0);
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_valid", 32'(bus.oINSTR_VALID), 32'd0);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_count0", 32'(count), 32'd0);
    tick();
    tick();
    tick();
    chk("t3_valid_later", 32'(bus.oINSTR_VALID), 32'd0);

    // Hold the core off for 10 cycles with 5 words queued
    bus.iINSTR_READY = 1'b0;
    for (int i = 0; i < 5; i++) cmd(2'd0, 32'h50 + 32'(i));
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_data", bus.oINSTR, 32'h50);
      chk("t4_hold_count", 32'(count), 32'd5);
      tick();
    end
    bus.iINSTR_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_pop_data", bus.oINSTR, 32'h50 + 32'(i));
      tick();
    end
    chk("t4_empty", 32'(empty), 32'd1);

    // Streaming simultaneous push+pop across pointer wrap
    bus.iINSTR_READY = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      cmd(2'd0, 32'h100 + 32'(i));
      exp_q.push_back(32'h100 + 32'(i));
    end
    tick();
    bus.iINSTR_READY = 1'b1;
    bus.iCMD_OP      = 2'd0;
    for (int i = 0; i < 40; i++) begin
      bus.iCMD_VALID = 1'b1;
      bus.iCMD_DATA  = 32'h200 + 32'(i);
      exp_q.push_back(32'h200 + 32'(i));
      chk("t5_stream_data", bus.oINSTR, exp_q.pop_front());
      chk("t5_stream_count", 32'(count), 32'd3);
      tick();
    end
    bus.iCMD_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_tail_data", bus.oINSTR, exp_q.pop_front());
      tick();
    end
    chk("t5_empty", 32'(empty), 32'd1);

    // Status snapshot: 6 pushes, 2 pops
    cmd(2'd1, 32'h0);
    bus.iINSTR_READY = 1'b0;
    for (int i = 0; i < 6; i++) cmd(2'd0, 32'h60 + 32'(i));
    tick();
    tick();
    bus.iINSTR_READY = 1'b1;
    tick();
    tick();
    bus.iINSTR_READY = 1'b0;
    chk("t6_count4", 32'(count), 32'd4);
    chk("t6_head", bus.oINSTR, 32'h62);
    cmd(2'd2, 32'h0);
`ifdef GPPCU_CMDQ_STATS_EN
    exp_status = 32'h0020_0004;
`else
    exp_status = 32'h0000_0004;
`endif
    chk("t6_status", status, exp_status);

    // Almost-full threshold boundary and reserved op
    cmd(2'd0, 32'h66);
    chk("t7_count5", 32'(count), 32'd5);
    chk("t7_af_below", 32'(almost_full), 32'd0);
    cmd(2'd0, 32'h67);
    chk("t7_af_at", 32'(almost_full), 32'd1);
    chk("t7_status_hold", status, exp_status);
    cmd(2'd3, 32'hDEAD);
    chk("t7_op3_count", 32'(count), 32'd6);
    chk("t7_op3_status", status, exp_status);

    // Reset mid-operation discards everything
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t8_count", 32'(count), 32'd0);
    chk("t8_valid", 32'(bus.oINSTR_VALID), 32'd0);
    chk("t8_instr", bus.oINSTR, 32'd0);
    chk("t8_status", status, 32'd0);
    tick();
    tick();
    chk("t8_valid_later", 32'(bus.oINSTR_VALID), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
